// File: rtl/data_memory_ws.sv
// -----------------------------------------------------------------------------
// data_memory_ws
//
// Data memory with configurable word width, depth and wait-state latency.
// It sits between the core's load/store port and its read-data input.
// Each access is accepted in IDLE and stretched by WAIT wait states. It then
// completes with a one-cycle ready strobe, so multi-cycle or stall-capable
// cores can be served by a deliberately slow memory.
//
// Parameters:
//   DATA_W  data word width in bits
//   ADDR_W  address width in bits
//   DEPTH   implemented words (1..2^ADDR_W); addresses >= DEPTH are out of range
//   WAIT    wait states inserted before completion (0..15)
//
// Ports:
//   clk      rising-edge clock
//   reset    asynchronous, active-low reset (clears every word)
//   core_wr  write request
//   core_rd  read request
//   addr     word address
//   data_o   write data from core
//   data_i   read data to core (holds between read completions)
//   ready    one-cycle completion strobe
//   busy     access in progress; new requests are ignored while high
//   err      one-cycle strobe with ready: out-of-range access or rd+wr conflict
// -----------------------------------------------------------------------------
module data_memory_ws #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 32,
    parameter int WAIT   = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              core_wr,
    input  logic              core_rd,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_o,
    output logic [DATA_W-1:0] data_i,
    output logic              ready,
    output logic              busy,
    output logic              err
);

    // Configuration guards: an illegal parameter set stops elaboration.
    generate
        if (WAIT < 0 || WAIT > 15) begin : g_bad_wait
            $error("data_memory_ws: WAIT=%0d is outside 0..15", WAIT);
        end
        if (DEPTH < 1 || DEPTH > (1 << ADDR_W)) begin : g_bad_depth
            $error("data_memory_ws: DEPTH=%0d does not fit in ADDR_W=%0d", DEPTH, ADDR_W);
        end
    endgenerate

    localparam logic [ADDR_W:0] DEPTH_L   = (ADDR_W + 1)'(DEPTH);
    localparam logic [3:0]      WAIT_L    = 4'(WAIT);
    localparam bit              ZERO_WAIT = (WAIT == 0);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t              state_reg;
    logic [3:0]          cnt_reg;
    logic [ADDR_W-1:0]   addr_reg;
    logic [DATA_W-1:0]   wdata_reg;
    logic                wr_reg;
    logic                conflict_reg;

    // Every word must clear on reset, so the array is register-based.
    logic [DATA_W-1:0]   mem [DEPTH];

    logic                req;
    logic                accept;
    logic                complete;
    logic [ADDR_W-1:0]   acc_addr;
    logic [DATA_W-1:0]   acc_wdata;
    logic                acc_wr;
    logic                acc_conflict;
    logic                in_range;
    logic [DATA_W-1:0]   rd_word;

    always_comb begin
        req    = core_rd | core_wr;
        accept = (state_reg == ST_IDLE) && req;

        // With WAIT=0 the access completes on its accepting edge. It must
        // therefore use the live request, not the copy latched on that edge.
        if (state_reg == ST_IDLE) begin
            acc_addr     = addr;
            acc_wdata    = data_o;
            acc_wr       = core_wr;
            acc_conflict = core_wr & core_rd;
        end else begin
            acc_addr     = addr_reg;
            acc_wdata    = wdata_reg;
            acc_wr       = wr_reg;
            acc_conflict = conflict_reg;
        end

        in_range = {1'b0, acc_addr} < DEPTH_L;
        rd_word  = in_range ? mem[acc_addr] : '0;

        // Completion edge: the accepting edge when there are no wait states,
        // otherwise the edge on which the wait counter steps from 1 to 0.
        complete = (accept && ZERO_WAIT) ||
                   ((state_reg == ST_WAIT) && (cnt_reg == 4'd1));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= '0;
            addr_reg     <= '0;
            wdata_reg    <= '0;
            wr_reg       <= 1'b0;
            conflict_reg <= 1'b0;
            data_i       <= '0;
            ready        <= 1'b0;
            busy         <= 1'b0;
            err          <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            // Strobes default low so they last exactly the RESP cycle.
            ready <= 1'b0;
            err   <= 1'b0;

            if (complete) begin
                if (acc_wr) begin
                    // A rd+wr conflict also lands here: it behaves as a write.
                    if (in_range) begin
                        mem[acc_addr] <= acc_wdata;
                    end
                end else begin
                    data_i <= rd_word;
                end
                ready <= 1'b1;
                err   <= !in_range || acc_conflict;
            end

            case (state_reg)
                ST_IDLE: begin
                    if (req) begin
                        addr_reg     <= addr;
                        wdata_reg    <= data_o;
                        wr_reg       <= core_wr;
                        conflict_reg <= core_wr & core_rd;
                        busy         <= 1'b1;
                        if (ZERO_WAIT) begin
                            state_reg <= ST_RESP;
                        end else begin
                            state_reg <= ST_WAIT;
                            cnt_reg   <= WAIT_L;
                        end
                    end
                end
                ST_WAIT: begin
                    cnt_reg <= cnt_reg - 4'd1;
                    if (cnt_reg == 4'd1) begin
                        state_reg <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    state_reg <= ST_IDLE;
                    busy      <= 1'b0;
                end
                default: begin
                    state_reg <= ST_IDLE;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
